sram_port_master: RTL and testbench
===================================

Name: sram_port_master

Overview:
- Host-side controller that is the initiator for one OpenRAM 1RW SRAM port (csb0/web0/addr0/din0/dout0).
- Converts a valid/ready request stream into per-cycle SRAM commands and captures read data into a response FIFO.
- After reset it optionally clears the whole array before accepting traffic.
- Sits between a bus adapter/core and a sram_1rw0r0w_*_freepdk45 macro.

Parameters:
DATA_WIDTH, 32, word width (matches macro)
ADDR_WIDTH, 11, address width; RAM_DEPTH = 1<<ADDR_WIDTH
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
CLEAR_ON_RESET, 1, 1 = write CLEAR_VALUE to every word after reset
CLEAR_VALUE, 0, data written during clear

Ports:
clk0  in  1  clock, shared with SRAM clk0
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at posedge
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer takes data when valid&ready at posedge
rsp_rdata  out  DATA_WIDTH  read data, in request order
init_done  out  1  clear complete; traffic allowed
csb0  out  1  SRAM active-low chip select
web0  out  1  SRAM active-low write enable
addr0  out  ADDR_WIDTH  SRAM address
din0  out  DATA_WIDTH  SRAM write data
dout0  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset (rst_n=0 at posedge): csb0=1, web0=1, addr0=0, din0=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, FIFO empty, in-flight count 0, clear counter 0. Reset mid-clear or mid-traffic discards all in-flight reads and restarts from CLEAR (or RUN if CLEAR_ON_RESET=0).
- All SRAM outputs are flops on posedge clk0. The SRAM samples them at the following posedge.
- FSM:
  - CLEAR: each cycle drives csb0=0, web0=0, addr0=clear counter, din0=CLEAR_VALUE. The counter runs 0..RAM_DEPTH-1. After the last address is issued, go to RUN. req_ready=0 throughout.
  - RUN: init_done=1. init_done is set the cycle after the last clear write is issued and is never cleared except by reset.
  - CLEAR_ON_RESET=0: go directly to RUN on the first cycle after reset.
- RUN issue:
  - Acceptance at posedge t loads csb0=0, web0=~req_we, addr0=req_addr, din0=req_wdata.
  - No acceptance at t loads csb0=1, web0=1; addr0/din0 hold.
  - Exactly one command per cycle, back-to-back allowed.
- Read latency:
  - Accept at t. SRAM samples at t+1, and dout0 settles after negedge t+1 (+DELAY).
  - Controller captures dout0 into the FIFO at posedge t+2. rsp_valid=1 from t+2.
  - Read-to-response latency is 2 cycles when the FIFO is empty.
  - A 2-stage valid pipe tracks in-flight reads. Writes occupy no pipe slot.
- Credit rule: req_ready = RUN && (fifo_count + inflight_reads < RSP_DEPTH). req_ready does not depend on req_we or req_valid. The FIFO can never overflow, so no capture is ever dropped.
- FIFO:
  - In-order.
  - Simultaneous push and pop when full or empty is legal and keeps the count.
  - rsp_rdata holds the head entry. rsp_rdata and rsp_valid are stable while rsp_valid && !rsp_ready.
- Ordering:
  - Write to A at t, then read of A at t+1: the read returns the new data, because the SRAM writes at negedge t+1 and reads at negedge t+2.
  - Read of A at t, then write of A at t+1: the read returns the old data.
- Address wrap: addresses are used as-is with no increment logic, except the clear counter, which stops at RAM_DEPTH-1 and does not wrap.
- Idle SRAM cycles always have csb0=1, so the macro sees no spurious access.

Test Plan:
1. Reset, then CLEAR_ON_RESET=1, RAM_DEPTH=2048: csb0=0/web0=0 for exactly 2048 consecutive cycles with addr0 0..2047. init_done rises on the next cycle. Then a read of 0x7FF returns 0x00000000.
2. Write 0x7FF<-0xDEADBEEF, then a read of 0x7FF on the next cycle: rsp_valid 2 cycles after read acceptance, rsp_rdata=0xDEADBEEF.
3. Back-to-back reads of 0x001..0x004 (preloaded 0x11..0x44), rsp_ready=1: four consecutive rsp_valid cycles, data 0x11,0x22,0x33,0x44 in order, with no idle gap.
4. rsp_ready=0 while issuing 6 reads: req_ready drops after 4 accepted reads. Then rsp_ready=1: all 6 responses arrive in order with no loss, and req_ready reasserts the cycle after the first pop.
5. Read 0x010 (old 0xAAAA0000) followed immediately by write 0x010<-0x5555FFFF: the response is 0xAAAA0000, and a later read returns 0x5555FFFF.
6. rst_n=0 for one cycle midway through the clear (counter ~1000), and separately with 2 reads in flight: outputs return to reset values. The clear restarts at addr0=0. No stale rsp_valid appears.

Source files
------------

// File: rtl/sram_port_master_if.sv
// Request/response stream between a host-side adapter and sram_port_master.
interface sram_port_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_port_master.sv
// Initiator for one OpenRAM 1RW port: optional post-reset clear, then one
// registered SRAM command per accepted request with read data returned through a FIFO.
module sram_port_master #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 11,
   parameter int                    RSP_DEPTH      = 4,
   parameter bit                    CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                  clk0,
   input  logic                  rst_n,
   sram_port_master_if.slave     host,
   output logic                  init_done,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam logic [PW:0] DEPTH_L = (PW+1)'(RSP_DEPTH);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;
   localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] clear_cnt;
   logic [ADDR_WIDTH-1:0] clear_cnt_next;
   logic                  csb_next;
   logic                  web_next;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [DATA_WIDTH-1:0] din_next;

   logic                  accept;
   logic                  req_ready_int;
   logic                  rsp_valid_int;
   logic [1:0]            rd_pipe;
   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           fifo_count;
   logic [PW:0]           pending;
   logic                  push;
   logic                  pop;

   // Every read holds a FIFO slot from acceptance on, so captures can never overflow.
   assign pending       = fifo_count + (PW+1)'(rd_pipe[0]) + (PW+1)'(rd_pipe[1]);
   assign req_ready_int = init_done && (state == ST_RUN) && (pending < DEPTH_L);
   assign accept        = host.req_valid && req_ready_int;
   assign rsp_valid_int = (fifo_count != '0);
   assign push          = rd_pipe[1];
   assign pop           = rsp_valid_int && host.rsp_ready;

   assign host.req_ready = req_ready_int;
   assign host.rsp_valid = rsp_valid_int;
   assign host.rsp_rdata = rsp_valid_int ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk0) begin
      if (!rst_n) begin
         state     <= RESET_STATE;
         clear_cnt <= '0;
      end else begin
         state     <= state_next;
         clear_cnt <= clear_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      clear_cnt_next = clear_cnt;
      csb_next       = 1'b1;
      web_next       = 1'b1;
      addr_next      = addr0;
      din_next       = din0;
      case (state)
         ST_CLEAR: begin
            csb_next  = 1'b0;
            web_next  = 1'b0;
            addr_next = clear_cnt;
            din_next  = CLEAR_VALUE;
            // The counter parks on the last word rather than wrapping.
            if (clear_cnt == '1) begin
               state_next = ST_RUN;
            end else begin
               clear_cnt_next = clear_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (accept) begin
               csb_next  = 1'b0;
               web_next  = ~host.req_we;
               addr_next = host.req_addr;
               din_next  = host.req_wdata;
            end
         end
         default: state_next = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk0) begin
      if (!rst_n) begin
         csb0      <= 1'b1;
         web0      <= 1'b1;
         addr0     <= '0;
         din0      <= '0;
         init_done <= 1'b0;
         rd_pipe   <= '0;
      end else begin
         csb0      <= csb_next;
         web0      <= web_next;
         addr0     <= addr_next;
         din0      <= din_next;
         init_done <= init_done | (state == ST_RUN);
         rd_pipe   <= {rd_pipe[0], accept && !host.req_we};
      end
   end

   always_ff @(posedge clk0) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk0) begin
      if (push) fifo_mem[wr_ptr] <= dout0;
   end
endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: OpenRAM-style SRAM model, request-order
// scoreboard, directed vector table, hand sequences and random traffic.
module tb_sram_port_master;
   localparam int DW        = 32;
   localparam int AW        = 11;
   localparam int DEPTH     = 2048;
   localparam int RSP_DEPTH = 4;

   logic          clk0 = 1'b0;
   logic          rst_n = 1'b0;
   logic          init_done;
   logic          csb0;
   logic          web0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0 = '0;

   sram_port_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) host();

   sram_port_master #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .RSP_DEPTH     (RSP_DEPTH),
      .CLEAR_ON_RESET(1'b1),
      .CLEAR_VALUE   (32'h0)
   ) dut (
      .clk0     (clk0),
      .rst_n    (rst_n),
      .host     (host),
      .init_done(init_done),
      .csb0     (csb0),
      .web0     (web0),
      .addr0    (addr0),
      .din0     (din0),
      .dout0    (dout0)
   );

   always #5 clk0 = ~clk0;

   int cyc = 0;
   always @(posedge clk0) cyc <= cyc + 1;

   // Macro model: latch command on posedge, access the array on the following negedge.
   logic [DW-1:0] sram_mem [DEPTH];
   logic          s_csb = 1'b1;
   logic          s_web = 1'b1;
   logic [AW-1:0] s_addr = '0;
   logic [DW-1:0] s_din = '0;
   logic [DW-1:0] rd_word;

   always @(posedge clk0) begin
      s_csb  <= csb0;
      s_web  <= web0;
      s_addr <= addr0;
      s_din  <= din0;
   end

   always @(negedge clk0) begin
      if (!s_csb && !s_web) begin
         sram_mem[s_addr] = s_din;
      end else if (!s_csb && s_web) begin
         rd_word = sram_mem[s_addr];
         #1 dout0 = rd_word;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string detail);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: %s", name, detail);
   endtask

   // Reference: memory contents and expected responses in request order.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] const_q[$];
   int            acc_log[$];
   int            pop_log[$];
   bit            acc_prev = 1'b0;
   bit            acc_we = 1'b0;
   logic [AW-1:0] last_addr = '1;
   logic [DW-1:0] last_din = '0;
   bit            hold_prev = 1'b0;
   logic [DW-1:0] hold_data = '0;

   always @(negedge clk0) begin
      if (rst_n) begin
         if (init_done) begin
            check_output("sram_csb", csb0, !acc_prev);
            check_output("sram_web", web0, acc_prev ? !acc_we : 1'b1);
            check_output("sram_addr", addr0, last_addr);
            check_output("sram_din", din0, last_din);
         end
         check_output("req_ready", host.req_ready, init_done && (model_q.size() < RSP_DEPTH));
         if (hold_prev) begin
            check_output("rsp_hold_valid", host.rsp_valid, 1'b1);
            check_output("rsp_hold_data", host.rsp_rdata, hold_data);
         end
         if (host.rsp_valid && host.rsp_ready) begin
            pop_log.push_back(cyc);
            if (model_q.size() == 0)
               fail_now("stale_rsp", $sformatf("got rsp 0x%0h, required no response", host.rsp_rdata));
            else
               check_output("rsp_data", host.rsp_rdata, model_q.pop_front());
            if (const_q.size() > 0)
               check_output("rsp_table", host.rsp_rdata, const_q.pop_front());
         end
         acc_prev = host.req_valid && host.req_ready;
         if (acc_prev) begin
            acc_we    = host.req_we;
            last_addr = host.req_addr;
            last_din  = host.req_wdata;
            if (host.req_we) begin
               ref_mem[host.req_addr] = host.req_wdata;
            end else begin
               model_q.push_back(ref_mem[host.req_addr]);
               acc_log.push_back(cyc + 1);
            end
         end
         hold_prev = host.rsp_valid && !host.rsp_ready;
         hold_data = host.rsp_rdata;
      end else begin
         acc_prev  = 1'b0;
         hold_prev = 1'b0;
         last_addr = '1;
         last_din  = '0;
      end
   end

   // Entered just after a posedge; leaves rst_n high at the negedge after the reset edge.
   task automatic do_reset();
      rst_n = 1'b0;
      model_q.delete();
      const_q.delete();
      pop_log.delete();
      acc_log.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      @(posedge clk0);
      #1 rst_n = 1'b1;
      @(negedge clk0);
      check_output("rst_csb0", csb0, 1'b1);
      check_output("rst_web0", web0, 1'b1);
      check_output("rst_addr0", addr0, '0);
      check_output("rst_din0", din0, '0);
      check_output("rst_req_ready", host.req_ready, 1'b0);
      check_output("rst_rsp_valid", host.rsp_valid, 1'b0);
      check_output("rst_rsp_rdata", host.rsp_rdata, '0);
      check_output("rst_init_done", init_done, 1'b0);
   endtask

   task automatic wait_clear();
      int n = 0;
      int bad = 0;
      int last = -10;
      int rise = -100;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk0);
         if (init_done) begin
            rise = cyc;
            break;
         end
         if (host.rsp_valid) bad++;
         if (!csb0 && !web0) begin
            if (addr0 != AW'(n) || din0 != 32'h0) bad++;
            if (n > 0 && cyc != last + 1) bad++;
            last = cyc;
            n++;
         end
      end
      check_output("clear_count", n, DEPTH);
      check_output("clear_sequence", bad, 0);
      check_output("init_done_rise", rise - last, 1);
   endtask

   task automatic apply_stimulus(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int waited = 0;
      host.req_valid = 1'b1;
      host.req_we    = we;
      host.req_addr  = addr;
      host.req_wdata = data;
      do begin
         @(negedge clk0);
         if (host.req_ready) break;
         waited++;
      end while (waited < 200);
      if (waited >= 200) fail_now("req_timeout", "got no req_ready in 200 cycles, required acceptance");
      @(posedge clk0);
      #1 host.req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      host.rsp_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk0);
         if (model_q.size() == 0 && !host.rsp_valid) break;
      end
      check_output(name, model_q.size(), 0);
      @(posedge clk0);
      #1;
   endtask

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;
   vec_t vecs[11];

   initial begin
      int stall_bad;
      vecs[0]  = '{1'b0, 11'h7FF, 32'h0,        32'h00000000};
      vecs[1]  = '{1'b1, 11'h001, 32'h11,       32'h0};
      vecs[2]  = '{1'b1, 11'h002, 32'h22,       32'h0};
      vecs[3]  = '{1'b1, 11'h003, 32'h33,       32'h0};
      vecs[4]  = '{1'b1, 11'h004, 32'h44,       32'h0};
      vecs[5]  = '{1'b1, 11'h010, 32'hAAAA0000, 32'h0};
      vecs[6]  = '{1'b0, 11'h003, 32'h0,        32'h00000033};
      vecs[7]  = '{1'b0, 11'h010, 32'h0,        32'hAAAA0000};
      vecs[8]  = '{1'b1, 11'h010, 32'h5555FFFF, 32'h0};
      vecs[9]  = '{1'b0, 11'h010, 32'h0,        32'h5555FFFF};
      vecs[10] = '{1'b0, 11'h000, 32'h0,        32'h00000000};

      host.req_valid = 1'b0;
      host.req_we    = 1'b0;
      host.req_addr  = '0;
      host.req_wdata = '0;
      host.rsp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;

      // Power-up reset, then interrupt the clear around word 1000.
      do_reset();
      repeat (1000) @(negedge clk0);
      check_output("midclear_csb0", csb0, 1'b0);
      check_output("midclear_addr0", addr0, 11'd999);
      @(posedge clk0);
      #1 do_reset();
      wait_clear();
      @(posedge clk0);
      #1;

      $display("[TB] directed vector table");
      for (int i = 0; i < 11; i++) begin
         if (!vecs[i].we) const_q.push_back(vecs[i].exp_rdata);
         apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      end
      wait_drain("table_drain");
      check_output("table_const_left", const_q.size(), 0);

      $display("[TB] write then read latency");
      acc_log.delete();
      pop_log.delete();
      apply_stimulus(1'b1, 11'h7FF, 32'hDEADBEEF);
      const_q.push_back(32'hDEADBEEF);
      apply_stimulus(1'b0, 11'h7FF, 32'h0);
      wait_drain("lat_drain");
      check_output("lat_count", pop_log.size(), 1);
      if (pop_log.size() == 1 && acc_log.size() == 1)
         check_output("read_latency", pop_log[0] - acc_log[0], 2);

      $display("[TB] back-to-back reads");
      pop_log.delete();
      for (int k = 1; k <= 4; k++) begin
         const_q.push_back(32'(k * 'h11));
         apply_stimulus(1'b0, AW'(k), 32'h0);
      end
      wait_drain("b2b_drain");
      check_output("b2b_count", pop_log.size(), 4);
      for (int k = 1; k < pop_log.size(); k++)
         check_output("b2b_gap", pop_log[k] - pop_log[k-1], 1);

      $display("[TB] response back-pressure and credits");
      host.rsp_ready = 1'b0;
      acc_log.delete();
      for (int k = 1; k <= 4; k++) begin
         const_q.push_back(32'(k * 'h11));
         apply_stimulus(1'b0, AW'(k), 32'h0);
      end
      host.req_valid = 1'b1;
      host.req_we    = 1'b0;
      host.req_addr  = 11'h010;
      host.req_wdata = '0;
      const_q.push_back(32'h5555FFFF);
      stall_bad = 0;
      repeat (6) begin
         @(negedge clk0);
         if (host.req_ready) stall_bad++;
      end
      check_output("credit_stall", stall_bad, 0);
      #1 check_output("credit_accepted", acc_log.size(), 4);
      check_output("fifo_full_valid", host.rsp_valid, 1'b1);
      @(posedge clk0);
      #1 host.rsp_ready = 1'b1;
      @(negedge clk0);
      check_output("ready_before_pop", host.req_ready, 1'b0);
      @(negedge clk0);
      check_output("ready_after_pop", host.req_ready, 1'b1);
      @(posedge clk0);
      #1;
      const_q.push_back(32'hDEADBEEF);
      apply_stimulus(1'b0, 11'h7FF, 32'h0);
      wait_drain("credit_drain");
      check_output("credit_total", acc_log.size(), 6);
      check_output("credit_const_left", const_q.size(), 0);

      $display("[TB] reset with reads in flight");
      apply_stimulus(1'b0, 11'h001, 32'h0);
      apply_stimulus(1'b0, 11'h002, 32'h0);
      do_reset();
      wait_clear();
      check_output("no_stale_rsp", pop_log.size(), 0);
      @(posedge clk0);
      #1;

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         host.req_valid = ($urandom_range(0, 9) < 7);
         host.req_we    = ($urandom_range(0, 1) == 1);
         host.req_addr  = ($urandom_range(0, 3) == 0) ? AW'(11'h7F0 + $urandom_range(0, 15))
                                                      : AW'($urandom_range(0, 15));
         host.req_wdata = $urandom;
         host.rsp_ready = ($urandom_range(0, 9) < 6);
         @(posedge clk0);
         #1;
      end
      host.req_valid = 1'b0;
      wait_drain("random_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
